// File: rtl/soc_mem_bank.sv
// Single-port word-addressed memory bank with byte strobes and a fixed-latency response pipeline.
// Every request (read or write) returns exactly one response READ_LATENCY cycles after acceptance.
module soc_mem_bank #(
  parameter int MEM_AW       = 10,
  parameter int MEM_DW       = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk_i,
  input  logic                arst_ni,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [MEM_AW-1:0]   mem_addr_i,
  input  logic [MEM_DW-1:0]   mem_wdata_i,
  input  logic [MEM_DW/8-1:0] mem_strb_i,
  output logic                mem_rvalid_o,
  output logic [MEM_DW-1:0]   mem_rdata_o,
  output logic                busy_o
);

  localparam int NB    = MEM_DW / 8;
  localparam int DEPTH = 1 << MEM_AW;

  if ((MEM_DW % 8) != 0 || MEM_DW < 8 || MEM_DW > 1024) begin : g_bad_dw
    $fatal(1, "soc_mem_bank: MEM_DW must be a multiple of 8 in 8..1024");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
    $fatal(1, "soc_mem_bank: READ_LATENCY must be in 1..4");
  end

  logic [MEM_DW-1:0]       mem_q [DEPTH];
  logic [MEM_DW-1:0]       rd_word;
  logic [MEM_DW-1:0]       merged_word;
  logic [MEM_DW-1:0]       resp_word;
  logic [READ_LATENCY-1:0] vld_q;
  logic [MEM_DW-1:0]       dat_q [READ_LATENCY];

  // The response of a write is the merged word, so read-after-write needs no bypass.
  always_comb begin
    rd_word     = mem_q[mem_addr_i];
    merged_word = rd_word;
    for (int b = 0; b < NB; b++) begin
      if (mem_strb_i[b]) merged_word[b*8 +: 8] = mem_wdata_i[b*8 +: 8];
    end
    resp_word = mem_we_i ? merged_word : rd_word;
  end

  // Storage is deliberately not reset so contents survive arst_ni pulses.
  always_ff @(posedge clk_i) begin
    if (mem_req_i && mem_we_i) mem_q[mem_addr_i] <= merged_word;
  end

  // Data stages only advance behind a valid bit, so the output holds the last response.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= mem_req_i;
      if (mem_req_i) dat_q[0] <= resp_word;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign mem_rvalid_o = vld_q[READ_LATENCY-1];
  assign mem_rdata_o  = dat_q[READ_LATENCY-1];
  assign busy_o       = |vld_q;

endmodule

// File: tb/tb_soc_mem_bank.sv
// Bench for soc_mem_bank: three instances (latency 2, 3, 4) share one request stream and are
// checked against a request log plus a byte-merging reference memory and hand-computed vectors.
module tb_soc_mem_bank;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [9:0]  mem_addr_i;
  logic [63:0] mem_wdata_i;
  logic [7:0]  mem_strb_i;
  logic        rv [3];
  logic [63:0] rd [3];
  logic        bz [3];

  always #5 clk_i = ~clk_i;

  soc_mem_bank #(.MEM_AW(10), .MEM_DW(64), .READ_LATENCY(2)) u_l2 (
    .clk_i(clk_i), .arst_ni(arst_ni), .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_strb_i(mem_strb_i),
    .mem_rvalid_o(rv[0]), .mem_rdata_o(rd[0]), .busy_o(bz[0]));

  soc_mem_bank #(.MEM_AW(10), .MEM_DW(64), .READ_LATENCY(3)) u_l3 (
    .clk_i(clk_i), .arst_ni(arst_ni), .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_strb_i(mem_strb_i),
    .mem_rvalid_o(rv[1]), .mem_rdata_o(rd[1]), .busy_o(bz[1]));

  soc_mem_bank #(.MEM_AW(10), .MEM_DW(64), .READ_LATENCY(4)) u_l4 (
    .clk_i(clk_i), .arst_ni(arst_ni), .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_strb_i(mem_strb_i),
    .mem_rvalid_o(rv[2]), .mem_rdata_o(rd[2]), .busy_o(bz[2]));

  typedef struct {
    bit          req;
    bit          we;
    logic [9:0]  addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    bit          ev2;
    logic [63:0] ed2;
    bit          ev3;
    logic [63:0] ed3;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc = 0;
  int          valid_from = 0;
  int          n_req = 0;
  int          n_rsp [3];
  logic [63:0] ref_mem [16];
  logic        hist_v [16384];
  logic [63:0] hist_d [16384];
  vec_t        tbl [16];

  function automatic logic [63:0] pat(int k);
    if (k == 9) return 64'h0;
    return {32'hC0DE0000 | k, 32'h5A5A0000 | k};
  endfunction

  function automatic logic [63:0] bexp(int a);
    if (a == 5) return 64'h11223344AAAAAAAA;
    return pat(a);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (step %0d)", nm, act, exp, cyc);
    end
  endtask

  // Response for latency L after step t comes from the request logged at step t-L+1.
  task automatic check_outputs();
    for (int k = 0; k < 3; k++) begin
      int          lat = k + 2;
      int          j = cyc - lat + 1;
      logic        ev = 1'b0;
      logic        eb = 1'b0;
      logic [63:0] ed = '0;
      if (j >= valid_from && j >= 0) begin
        ev = hist_v[j];
        ed = hist_d[j];
      end
      for (int m = j; m <= cyc; m++) begin
        if (m >= valid_from && m >= 0 && hist_v[m]) eb = 1'b1;
      end
      chk($sformatf("sb_rvalid_L%0d", lat), 64'(rv[k]), 64'(ev));
      if (ev) chk($sformatf("sb_rdata_L%0d", lat), rd[k], ed);
      chk($sformatf("sb_busy_L%0d", lat), 64'(bz[k]), 64'(eb));
      if (rv[k] === 1'b1) n_rsp[k]++;
    end
  endtask

  task automatic step(bit r, bit w, logic [9:0] a, logic [63:0] wd, logic [7:0] sb);
    mem_req_i   = r;
    mem_we_i    = w;
    mem_addr_i  = a;
    mem_wdata_i = wd;
    mem_strb_i  = sb;
    hist_v[cyc] = r;
    hist_d[cyc] = '0;
    if (r) begin
      n_req++;
      if (w) begin
        for (int b = 0; b < 8; b++) begin
          if (sb[b]) ref_mem[a[3:0]][b*8 +: 8] = wd[b*8 +: 8];
        end
      end
      hist_d[cyc] = ref_mem[a[3:0]];
    end
    @(posedge clk_i);
    #1;
    check_outputs();
    cyc++;
  endtask

  // Idle cycles carry junk on the qualified inputs; it must be ignored.
  task automatic idle();
    step(1'b0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
         {$urandom, $urandom}, 8'($urandom_range(0, 255)));
  endtask

  task automatic chk_reset_outputs(string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_rvalid_%0d", tag, k), 64'(rv[k]), 64'h0);
      chk($sformatf("%s_rdata_%0d", tag, k), rd[k], 64'h0);
      chk($sformatf("%s_busy_%0d", tag, k), 64'(bz[k]), 64'h0);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) n_rsp[k] = 0;
    tbl[0]  = '{1, 1, 10'd5, 64'h1122334455667788, 8'hFF, 0, 64'h0, 0, 64'h0};
    tbl[1]  = '{1, 0, 10'd5, 64'h0, 8'h00, 1, 64'h1122334455667788, 0, 64'h0};
    tbl[2]  = '{0, 0, 10'd0, 64'h0, 8'h00, 1, 64'h1122334455667788, 1, 64'h1122334455667788};
    tbl[3]  = '{0, 0, 10'd0, 64'h0, 8'h00, 0, 64'h0, 1, 64'h1122334455667788};
    tbl[4]  = '{1, 1, 10'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, 64'h0, 0, 64'h0};
    tbl[5]  = '{1, 0, 10'd5, 64'h0, 8'h00, 1, 64'h11223344AAAAAAAA, 0, 64'h0};
    tbl[6]  = '{0, 0, 10'd0, 64'h0, 8'h00, 1, 64'h11223344AAAAAAAA, 1, 64'h11223344AAAAAAAA};
    tbl[7]  = '{0, 0, 10'd0, 64'h0, 8'h00, 0, 64'h0, 1, 64'h11223344AAAAAAAA};
    tbl[8]  = '{1, 0, 10'd9, 64'h0, 8'h00, 0, 64'h0, 0, 64'h0};
    tbl[9]  = '{1, 1, 10'd9, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1, 64'h0, 0, 64'h0};
    tbl[10] = '{0, 0, 10'd0, 64'h0, 8'h00, 1, 64'hFFFFFFFFFFFFFFFF, 1, 64'h0};
    tbl[11] = '{0, 0, 10'd0, 64'h0, 8'h00, 0, 64'h0, 1, 64'hFFFFFFFFFFFFFFFF};
    tbl[12] = '{0, 0, 10'd0, 64'h0, 8'h00, 0, 64'h0, 0, 64'h0};
    tbl[13] = '{1, 1, 10'd5, 64'h0, 8'h00, 0, 64'h0, 0, 64'h0};
    tbl[14] = '{0, 0, 10'd0, 64'h0, 8'h00, 1, 64'h11223344AAAAAAAA, 0, 64'h0};
    tbl[15] = '{0, 0, 10'd0, 64'h0, 8'h00, 0, 64'h0, 1, 64'h11223344AAAAAAAA};

    arst_ni     = 1'b0;
    mem_req_i   = 1'b0;
    mem_we_i    = 1'b0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
    mem_strb_i  = '0;
    #12;
    chk_reset_outputs("por");
    @(posedge clk_i);
    #1;
    arst_ni    = 1'b1;
    valid_from = cyc;

    // Known contents for the addresses used below; addr 9 starts at zero.
    for (int k = 0; k < 16; k++) step(1'b1, 1'b1, 10'(k), pat(k), 8'hFF);
    repeat (4) idle();

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].strb);
      chk($sformatf("tbl%0d_rvalid_L2", i), 64'(rv[0]), 64'(tbl[i].ev2));
      if (tbl[i].ev2) chk($sformatf("tbl%0d_rdata_L2", i), rd[0], tbl[i].ed2);
      chk($sformatf("tbl%0d_rvalid_L3", i), 64'(rv[1]), 64'(tbl[i].ev3));
      if (tbl[i].ev3) chk($sformatf("tbl%0d_rdata_L3", i), rd[1], tbl[i].ed3);
    end
    repeat (4) idle();

    // Back-to-back reads of 0..7 on the latency-3 instance.
    for (int i = 0; i < 12; i++) begin
      if (i < 8) step(1'b1, 1'b0, 10'(i), 64'h0, 8'h00);
      else       idle();
      chk($sformatf("burst%0d_rvalid", i), 64'(rv[1]), 64'(i >= 2 && i <= 9));
      if (i >= 2 && i <= 9) chk($sformatf("burst%0d_rdata", i), rd[1], bexp(i - 2));
      chk($sformatf("burst%0d_busy", i), 64'(bz[1]), 64'(i <= 9));
    end

    // Three reads, then reset before the latency-4 instance responds to any of them.
    step(1'b1, 1'b0, 10'd5, 64'h0, 8'h00);
    step(1'b1, 1'b0, 10'd6, 64'h0, 8'h00);
    step(1'b1, 1'b0, 10'd7, 64'h0, 8'h00);
    chk("pre_rst_rvalid_L4", 64'(rv[2]), 64'h0);
    chk("pre_rst_busy_L4", 64'(bz[2]), 64'h1);
    arst_ni   = 1'b0;
    mem_req_i = 1'b0;
    #1;
    chk_reset_outputs("rst_a");
    @(posedge clk_i);
    #1;
    chk_reset_outputs("rst_b");
    arst_ni    = 1'b1;
    valid_from = cyc;
    for (int i = 0; i < 5; i++) begin
      idle();
      chk($sformatf("post_rst%0d_rvalid_L4", i), 64'(rv[2]), 64'h0);
      chk($sformatf("post_rst%0d_busy_L4", i), 64'(bz[2]), 64'h0);
    end
    step(1'b1, 1'b0, 10'd5, 64'h0, 8'h00);
    idle();
    chk("retain_rvalid_L2", 64'(rv[0]), 64'h1);
    chk("retain_rdata_L2", rd[0], 64'h11223344AAAAAAAA);
    repeat (4) idle();

    n_req = 0;
    for (int k = 0; k < 3; k++) n_rsp[k] = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        logic [7:0] sb;
        sb = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) sb = 8'h00;
        step(1'b1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)),
             {$urandom, $urandom}, sb);
      end else begin
        idle();
      end
    end
    repeat (4) idle();
    for (int k = 0; k < 3; k++) chk($sformatf("rand_count_L%0d", k + 2), 64'(n_rsp[k]), 64'(n_req));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_mem_bank.md
SOC_MEM_BANK -- requirements
Module: soc_mem_bank

Interface
REQ-001 The block SHALL provide parameter MEM_AW, default 10, word-address width; depth is 2**MEM_AW words.
REQ-002 The block SHALL provide parameter MEM_DW, default 64, data width in bits; legal values are multiples of 8, from 8 to 1024.
REQ-003 The block SHALL provide parameter READ_LATENCY, default 1, cycles from request acceptance to mem_rvalid_o; legal range is 1..4.
REQ-004 The block SHALL provide port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL provide port arst_ni, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL provide port mem_req_i, input, 1 bit, request valid; every request is accepted in its cycle, since the upstream grant is tied high.
REQ-007 The block SHALL provide port mem_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL provide port mem_addr_i, input, MEM_AW bits, word address, already base-relative.
REQ-009 The block SHALL provide port mem_wdata_i, input, MEM_DW bits, write data.
REQ-010 The block SHALL provide port mem_strb_i, input, MEM_DW/8 bits, byte write enables.
REQ-011 The block SHALL provide port mem_rvalid_o, output, 1 bit, response valid, one pulse per accepted request.
REQ-012 The block SHALL provide port mem_rdata_o, output, MEM_DW bits, response data.
REQ-013 The block SHALL provide port busy_o, output, 1 bit, high while any response is in flight.

Function
REQ-014 The block SHALL accept a request on every rising edge where mem_req_i=1; there is no back-pressure and no stall.
REQ-015 The block SHALL update, on a write request, exactly the bytes whose mem_strb_i bit is 1, at the acceptance edge; unstrobed bytes keep their value.
REQ-016 The block SHALL capture the array word at mem_addr_i into the response pipeline at the acceptance edge of a read request.
REQ-017 The block SHALL capture the post-write word (merged with the strobes) into the response pipeline at the acceptance edge of a write request.
REQ-018 The block SHALL produce a response for every request, read or write: mem_rvalid_o=1 for exactly one cycle, READ_LATENCY cycles after the acceptance edge.
REQ-019 The block SHALL implement the response delay as a READ_LATENCY-stage shift pipeline of {valid, data}; stage 0 loads at acceptance, the last stage drives mem_rvalid_o/mem_rdata_o.
REQ-020 The block SHALL NOT produce an extra response in idle cycles (mem_req_i=0); the corresponding pipeline slot carries valid=0.
REQ-021 The block SHALL hold mem_rdata_o at its last response value while mem_rvalid_o=0; this value is don't-care for checking.
REQ-022 The block SHALL sustain back-to-back requests every cycle, with responses returned in request order at one per cycle.
REQ-023 The block SHALL, when a read in cycle N+1 follows a write to the same address in cycle N, return the newly written data.
REQ-024 The block SHALL, when a write to an address is accepted while an earlier read of that address is still in the pipeline, leave the earlier response holding the old data.
REQ-025 The block SHALL treat an all-zero strobe on a write as a no-op update that still produces a response carrying the unchanged word.
REQ-026 The block SHALL ignore mem_we_i, mem_addr_i, mem_wdata_i and mem_strb_i when mem_req_i=0.
REQ-027 The block SHALL drive busy_o as the OR of all pipeline valid bits.
REQ-028 The block SHALL use an address width exactly MEM_AW, so that all addresses are in range and addressing does not wrap.

Reset
REQ-029 The block SHALL, while arst_ni=0, clear all pipeline valid bits asynchronously and drive mem_rvalid_o=0, mem_rdata_o=0 and busy_o=0.
REQ-030 The block SHALL NOT reset the storage array; its contents are preserved across reset and undefined after power-up.
REQ-031 The block SHALL discard responses in flight when reset asserts mid-operation; no late mem_rvalid_o pulse occurs after reset release.
REQ-032 The block SHALL accept requests from the first rising edge after arst_ni deasserts.
REQ-033 The block SHALL fatal-error in simulation at elaboration if MEM_DW%8!=0 or READ_LATENCY is outside 1..4.

Verification
REQ-034 The bench SHALL cover this scenario, with MEM_DW=64 and READ_LATENCY=2: write addr 5, data 0x1122334455667788, strb 0xFF at cycle 0, then read addr 5 at cycle 1 -> rvalid at cycles 2 and 3; cycle-3 rdata = 0x1122334455667788.
REQ-035 The bench SHALL cover this scenario: partial write over the stored word above, addr 5, data 0xAAAAAAAAAAAAAAAA, strb 0x0F, then a read -> rdata = 0x11223344AAAAAAAA.
REQ-036 The bench SHALL cover this scenario, with READ_LATENCY=3: reads of addr 0..7 on 8 consecutive cycles -> 8 consecutive rvalid cycles starting 3 cycles after the first, data in address order, busy_o high throughout.
REQ-037 The bench SHALL cover this scenario: a read of addr 9 (old value 0x0), then a write to addr 9 of 0xFF..FF with strb all-1 one cycle later, with READ_LATENCY=3 -> the read response is 0x0 and the write response is 0xFF..FF.
REQ-038 The bench SHALL cover this scenario: 3 reads issued, then arst_ni pulsed low for 1 cycle before their responses -> no rvalid during or after reset, busy_o=0; a subsequent read of a previously written address returns the pre-reset contents.
REQ-039 The bench SHALL cover this scenario: randomized req/we/strb traffic for 10k cycles against a reference byte-array model -> every response matches the model and the response count equals the request count.
